// File: rtl/fir_chan_decim.sv
// Multichannel decimating FIR: loads NCH*DECIMATION interleaved samples, runs one
// shared multiply per cycle over every channel's history, then emits one result per channel.
module fir_chan_decim #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS = 32,
    parameter int DECIMATION = 8,
    parameter int NCH = 2,
    parameter logic signed [TAPS*DATA_WIDTH-1:0] COEFF = '0,
    parameter int FRAC_BITS = 10,
    parameter int SATURATE = 0
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic signed [DATA_WIDTH-1:0]                   x_in,
    input  logic                                           x_empty,
    output logic                                           x_rd_en,
    output logic signed [DATA_WIDTH-1:0]                   y_out,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]       y_chan,
    output logic                                           y_wr_en,
    input  logic                                           y_out_full
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TAP_W = $clog2(TAPS);
    localparam int POP_N = NCH * DECIMATION;
    localparam int POP_W = (POP_N > 1) ? $clog2(POP_N) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W = PROD_W + $clog2(TAPS);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [POP_W-1:0] POP_LAST = POP_W'(POP_N - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;
    state_t state, state_next;

    logic [CH_W-1:0]  load_ch, mac_ch, out_ch, ch_p1;
    logic [POP_W-1:0] pop_cnt;
    logic [TAP_W-1:0] mac_tap;
    logic             mac_drain;

    logic signed [DATA_WIDTH-1:0] hist [NCH][TAPS];
    logic signed [DATA_WIDTH-1:0] coef [TAPS];
    logic signed [DATA_WIDTH-1:0] result [NCH];
    logic signed [DATA_WIDTH-1:0] hist_sel, coef_sel;

    logic signed [PROD_W-1:0] mult, prod_p1;
    logic                     vld_p1, first_p1, last_p1;
    logic signed [ACC_W-1:0]  acc_p2, acc_sum;

    // Floor shift, then clamp or wrap into the output width.
    function automatic logic signed [DATA_WIDTH-1:0] quantise(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> FRAC_BITS;
        if (SATURATE != 0) begin
            if (shifted > SAT_HI) shifted = SAT_HI;
            else if (shifted < SAT_LO) shifted = SAT_LO;
        end
        return shifted[DATA_WIDTH-1:0];
    endfunction

    for (genvar k = 0; k < TAPS; k++) begin : g_coef
        assign coef[k] = COEFF[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= S_LOAD;
        else        state <= state_next;
    end

    // Handshakes are gated by reset so nothing moves during the reset cycle itself.
    always_comb begin
        state_next = state;
        x_rd_en    = 1'b0;
        y_wr_en    = 1'b0;
        case (state)
            S_LOAD: begin
                x_rd_en = reset && !x_empty;
                if (x_rd_en && pop_cnt == POP_LAST) state_next = S_MAC;
            end
            S_MAC: begin
                if (mac_drain) state_next = S_OUT;
            end
            S_OUT: begin
                y_wr_en = reset && !y_out_full;
                if (y_wr_en && out_ch == CH_LAST) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            load_ch <= '0;
            pop_cnt <= '0;
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < TAPS; k++)
                    hist[c][k] <= '0;
        end else if (x_rd_en) begin
            hist[load_ch][0] <= x_in;
            for (int k = 1; k < TAPS; k++)
                hist[load_ch][k] <= hist[load_ch][k-1];
            load_ch <= (load_ch == CH_LAST) ? '0 : load_ch + 1'b1;
            pop_cnt <= (pop_cnt == POP_LAST) ? '0 : pop_cnt + 1'b1;
        end
    end

    // Walk taps within a channel, channels in order, then one drain cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mac_ch    <= '0;
            mac_tap   <= '0;
            mac_drain <= 1'b0;
        end else if (state == S_MAC) begin
            if (mac_drain) begin
                mac_drain <= 1'b0;
                mac_ch    <= '0;
                mac_tap   <= '0;
            end else if (mac_tap == TAP_LAST) begin
                mac_tap <= '0;
                if (mac_ch == CH_LAST) mac_drain <= 1'b1;
                else                   mac_ch <= mac_ch + 1'b1;
            end else begin
                mac_tap <= mac_tap + 1'b1;
            end
        end
    end

    // Stage p1: registered product
    assign hist_sel = hist[mac_ch][mac_tap];
    assign coef_sel = coef[mac_tap];
    assign mult = PROD_W'(hist_sel) * PROD_W'(coef_sel);

    always_ff @(posedge clock) begin
        if (!reset) vld_p1 <= 1'b0;
        else        vld_p1 <= (state == S_MAC) && !mac_drain;
    end

    always_ff @(posedge clock) begin
        prod_p1  <= mult;
        first_p1 <= (mac_tap == '0);
        last_p1  <= (mac_tap == TAP_LAST);
        ch_p1    <= mac_ch;
    end

    // Stage p2: accumulate, restart on each channel's first tap
    assign acc_sum = (first_p1 ? '0 : acc_p2)
                   + {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_p2 <= '0;
            for (int c = 0; c < NCH; c++) result[c] <= '0;
        end else if (vld_p1) begin
            acc_p2 <= acc_sum;
            if (last_p1) result[ch_p1] <= quantise(acc_sum);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)       out_ch <= '0;
        else if (y_wr_en) out_ch <= (out_ch == CH_LAST) ? '0 : out_ch + 1'b1;
    end

    assign y_out  = result[out_ch];
    assign y_chan = out_ch;

endmodule
